// File: rtl/line_pingpong_buffer_if.sv
// Producer/consumer bus of the line ping-pong buffer.
// The master side is whoever drives the line traffic; the buffer itself is the slave.
interface line_pingpong_buffer_if #(
    parameter int X_SIZE  = 640,
    parameter int DEPTH_W = 10
);
    localparam int AW = $clog2(X_SIZE);

    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [DEPTH_W-1:0] wr_data;
    logic               wr_line_done;
    logic               wr_ready;
    logic               start_req;
    logic               rd_line_valid;
    logic               rd_en;
    logic [AW-1:0]      rd_addr;
    logic [DEPTH_W-1:0] rd_data;
    logic               rd_data_valid;
    logic               rd_line_release;
    logic               err;

    modport master (
        output wr_en, wr_addr, wr_data, wr_line_done, rd_en, rd_addr, rd_line_release,
        input  wr_ready, start_req, rd_line_valid, rd_data, rd_data_valid, err
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_line_done, rd_en, rd_addr, rd_line_release,
        output wr_ready, start_req, rd_line_valid, rd_data, rd_data_valid, err
    );
endinterface

// File: rtl/line_pingpong_buffer.sv
// Two-bank line buffer: the producer fills one bank while the consumer reads the other,
// with a 0..2 fill count deciding who may advance.
module line_pingpong_buffer #(
    parameter int X_SIZE  = 640,
    parameter int DEPTH_W = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    line_pingpong_buffer_if.slave  bus
);
    localparam int AW = $clog2(X_SIZE);
    localparam logic [AW:0] XS = (AW+1)'(X_SIZE);

    logic [DEPTH_W-1:0] r_bank0 [X_SIZE];
    logic [DEPTH_W-1:0] r_bank1 [X_SIZE];

    logic [1:0]         r_cnt;
    logic               r_wbank;
    logic               r_rbank;
    logic               r_init;
    logic [DEPTH_W-1:0] r_rd_data;
    logic               r_rd_data_valid;
    logic               r_start_req;
    logic               r_err;

    logic               w_has_free;
    logic               w_has_line;
    logic               w_wr_addr_ok;
    logic               w_rd_addr_ok;
    logic               w_wr_acc;
    logic               w_rd_acc;
    logic               w_done_acc;
    logic               w_rel_acc;
    logic               w_err_set;
    logic               w_start_set;
    logic [1:0]         w_cnt_next;

    assign w_has_free   = (r_cnt != 2'd2);
    assign w_has_line   = (r_cnt != 2'd0);
    assign w_wr_addr_ok = ({1'b0, bus.wr_addr} < XS);
    assign w_rd_addr_ok = ({1'b0, bus.rd_addr} < XS);

    assign w_wr_acc   = bus.wr_en && w_has_free && w_wr_addr_ok;
    assign w_rd_acc   = bus.rd_en && w_has_line && w_rd_addr_ok;
    assign w_done_acc = bus.wr_line_done && w_has_free;
    assign w_rel_acc  = bus.rd_line_release && w_has_line;

    assign w_err_set = (bus.wr_en && !(w_has_free && w_wr_addr_ok))
                     || (bus.wr_line_done && !w_has_free)
                     || (bus.rd_line_release && !w_has_line)
                     || (bus.rd_en && !w_rd_addr_ok);

    always_comb begin
        w_cnt_next = r_cnt;
        if (w_done_acc && !w_rel_acc)
            w_cnt_next = r_cnt + 2'd1;
        else if (w_rel_acc && !w_done_acc)
            w_cnt_next = r_cnt - 2'd1;
    end

    // Ask for a new line whenever a bank has just become (or stays) free for the producer.
    assign w_start_set = !r_init
                       || (w_done_acc && (w_cnt_next != 2'd2))
                       || (w_rel_acc && !w_done_acc && (r_cnt == 2'd2));

    always_ff @(posedge clk) begin
        if (!reset && w_wr_acc) begin
            if (r_wbank)
                r_bank1[bus.wr_addr] <= bus.wr_data;
            else
                r_bank0[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt           <= 2'd0;
            r_wbank         <= 1'b0;
            r_rbank         <= 1'b0;
            r_init          <= 1'b0;
            r_rd_data       <= '0;
            r_rd_data_valid <= 1'b0;
            r_start_req     <= 1'b0;
            r_err           <= 1'b0;
        end else begin
            r_init          <= 1'b1;
            r_cnt           <= w_cnt_next;
            r_start_req     <= w_start_set;
            r_rd_data_valid <= w_rd_acc;
            if (w_done_acc)
                r_wbank <= ~r_wbank;
            if (w_rel_acc)
                r_rbank <= ~r_rbank;
            // Reads use the pre-edge read bank, even when released this same cycle.
            if (w_rd_acc)
                r_rd_data <= r_rbank ? r_bank1[bus.rd_addr] : r_bank0[bus.rd_addr];
            if (w_err_set)
                r_err <= 1'b1;
        end
    end

    assign bus.wr_ready      = w_has_free;
    assign bus.rd_line_valid = w_has_line;
    assign bus.rd_data       = r_rd_data;
    assign bus.rd_data_valid = r_rd_data_valid;
    assign bus.start_req     = r_start_req;
    assign bus.err           = r_err;
endmodule

// File: tb/tb_line_pingpong_buffer.sv
// Directed bench for line_pingpong_buffer: read data goes through a scoreboard queue,
// control flags are compared right after the clock edge.
module tb_line_pingpong_buffer;
    localparam int X_SIZE  = 640;
    localparam int DEPTH_W = 10;

    logic clk;
    logic reset;

    line_pingpong_buffer_if #(.X_SIZE(X_SIZE), .DEPTH_W(DEPTH_W)) bus ();

    line_pingpong_buffer #(.X_SIZE(X_SIZE), .DEPTH_W(DEPTH_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_pass  = 0;
    int n_total = 0;
    logic [DEPTH_W-1:0] exp_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else
            n_pass++;
    endtask

    // Scoreboard monitor: every valid read result must match the oldest expected word.
    always @(negedge clk) begin
        if (bus.rd_data_valid === 1'b1) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL rd_unexpected: got valid data 0x%0h, expected no read result", bus.rd_data);
            end else begin
                logic [DEPTH_W-1:0] e;
                e = exp_q.pop_front();
                if (bus.rd_data !== e)
                    $display("FAIL rd_data: got 0x%0h, expected 0x%0h", bus.rd_data, e);
                else
                    n_pass++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wr_en = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.wr_line_done = 1'b0;
        bus.rd_en = 1'b0;
        bus.rd_addr = '0;
        bus.rd_line_release = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        tick();
        tick();
        chk({tag, "_rst_wr_ready"}, bus.wr_ready, 1);
        chk({tag, "_rst_line_valid"}, bus.rd_line_valid, 0);
        chk({tag, "_rst_err"}, bus.err, 0);
        chk({tag, "_rst_start"}, bus.start_req, 0);
        chk({tag, "_rst_rd_valid"}, bus.rd_data_valid, 0);
        chk({tag, "_rst_rd_data"}, bus.rd_data, 0);
        reset = 1'b0;
        tick();
        chk({tag, "_start_pulse"}, bus.start_req, 1);
        tick();
        chk({tag, "_start_once"}, bus.start_req, 0);
    endtask

    // mode 0: data = addr, 1: constant cval, 2: (3*addr) mod 1024
    task automatic write_words(input int n, input int mode, input int cval);
        for (int a = 0; a < n; a++) begin
            bus.wr_en = 1'b1;
            bus.wr_addr = 10'(a);
            case (mode)
                0: bus.wr_data = 10'(a);
                1: bus.wr_data = 10'(cval);
                default: bus.wr_data = 10'(a * 3);
            endcase
            tick();
        end
        bus.wr_en = 1'b0;
    endtask

    task automatic pulse_done();
        bus.wr_line_done = 1'b1;
        tick();
        bus.wr_line_done = 1'b0;
    endtask

    task automatic pulse_release();
        bus.rd_line_release = 1'b1;
        tick();
        bus.rd_line_release = 1'b0;
    endtask

    task automatic read_word(input int addr, input int exp);
        exp_q.push_back(10'(exp));
        bus.rd_en = 1'b1;
        bus.rd_addr = 10'(addr);
        tick();
        bus.rd_en = 1'b0;
        tick();
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        tick();
        do_reset("init");

        // First line: data = addr
        write_words(X_SIZE, 0, 0);
        pulse_done();
        chk("l1_line_valid", bus.rd_line_valid, 1);
        chk("l1_start", bus.start_req, 1);
        chk("l1_wr_ready", bus.wr_ready, 1);
        read_word(5, 5);
        read_word(639, 639);
        read_word(0, 0);
        pulse_release();
        chk("l1_rel_empty", bus.rd_line_valid, 0);
        chk("l1_rel_nostart", bus.start_req, 0);

        // Two full lines without release
        write_words(X_SIZE, 1, 1);
        pulse_done();
        chk("fa_start", bus.start_req, 1);
        write_words(X_SIZE, 1, 2);
        pulse_done();
        chk("full_wr_ready", bus.wr_ready, 0);
        chk("full_nostart", bus.start_req, 0);
        chk("full_err_clear", bus.err, 0);
        bus.wr_en = 1'b1; bus.wr_addr = 10'd7; bus.wr_data = 10'h3FF;
        tick();
        bus.wr_en = 1'b0;
        chk("full_write_err", bus.err, 1);
        pulse_done();
        chk("full_done_ignored", bus.wr_ready, 0);
        chk("full_line_valid", bus.rd_line_valid, 1);
        read_word(7, 1);
        pulse_release();
        chk("full_rel_start", bus.start_req, 1);
        chk("full_rel_wr_ready", bus.wr_ready, 1);
        read_word(7, 2);
        chk("err_sticky", bus.err, 1);

        // cnt=1: simultaneous done + release, with a same-cycle read of the old bank
        write_words(X_SIZE, 2, 0);
        exp_q.push_back(10'h002);
        bus.wr_line_done = 1'b1;
        bus.rd_line_release = 1'b1;
        bus.rd_en = 1'b1;
        bus.rd_addr = 10'd10;
        tick();
        idle_inputs();
        chk("sim_start", bus.start_req, 1);
        chk("sim_line_valid", bus.rd_line_valid, 1);
        chk("sim_wr_ready", bus.wr_ready, 1);
        tick();
        read_word(10, 30);
        read_word(639, 893);

        // Protocol errors from a clean state
        do_reset("e1");
        bus.rd_en = 1'b1; bus.rd_addr = 10'd5;
        tick();
        bus.rd_en = 1'b0;
        chk("empty_rd_valid", bus.rd_data_valid, 0);
        chk("empty_rd_noerr", bus.err, 0);
        pulse_release();
        chk("empty_rel_err", bus.err, 1);
        chk("empty_rel_nostart", bus.start_req, 0);
        chk("empty_rel_line_valid", bus.rd_line_valid, 0);

        do_reset("e2");
        for (int a = 0; a < 20; a++) begin
            bus.wr_en = 1'b1; bus.wr_addr = 10'(a); bus.wr_data = 10'(a + 100);
            tick();
        end
        bus.wr_en = 1'b0;
        pulse_done();
        read_word(12, 112);
        bus.rd_en = 1'b1; bus.rd_addr = 10'd640;
        tick();
        bus.rd_en = 1'b0;
        chk("badaddr_rd_valid", bus.rd_data_valid, 0);
        chk("badaddr_rd_hold", bus.rd_data, 112);
        chk("badaddr_err", bus.err, 1);

        // Reset in the middle of a line, with one line still buffered
        write_words(300, 0, 0);
        do_reset("mid");
        chk("mid_line_valid", bus.rd_line_valid, 0);
        chk("mid_err", bus.err, 0);

        tick();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/line_pingpong_buffer.md
LINE_PINGPONG_BUFFER -- requirements
Module: line_pingpong_buffer

Interface
REQ-001 SHALL have parameter X_SIZE, default 640, meaning pixels per line and words per bank.
REQ-002 SHALL have parameter DEPTH_W, default 10, meaning iteration-depth word width.
REQ-003 SHALL have localparam AW = $clog2(X_SIZE), meaning address width (10 at default).
REQ-004 SHALL have port clk  in  1  the only clock; all logic on its rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port wr_en  in  1  producer writes wr_data at wr_addr this cycle.
REQ-007 SHALL have port wr_addr  in  AW  pixel x index of the write.
REQ-008 SHALL have port wr_data  in  DEPTH_W  iteration depth of the pixel.
REQ-009 SHALL have port wr_line_done  in  1  single-cycle pulse: producer finished the current line.
REQ-010 SHALL have port wr_ready  out  1  a write bank is free.
REQ-011 SHALL have port start_req  out  1  single-cycle pulse telling the producer to begin a line.
REQ-012 SHALL have port rd_line_valid  out  1  a complete line is available to the consumer.
REQ-013 SHALL have port rd_en  in  1  consumer read request.
REQ-014 SHALL have port rd_addr  in  AW  pixel x index to read.
REQ-015 SHALL have port rd_data  out  DEPTH_W  registered read data.
REQ-016 SHALL have port rd_data_valid  out  1  rd_data holds the result of the previous cycle's accepted read.
REQ-017 SHALL have port rd_line_release  in  1  single-cycle pulse: consumer has finished with the line.
REQ-018 SHALL have port err  out  1  sticky protocol-error flag.

Function
REQ-019 SHALL hold two banks of X_SIZE x DEPTH_W storage, a 1-bit write-bank pointer wbank, a 1-bit read-bank pointer rbank, and a fill count cnt in {0,1,2}.
REQ-020 SHALL drive wr_ready = (cnt < 2) and rd_line_valid = (cnt > 0), both combinationally from registered state.
REQ-021 SHALL write bank[wbank][wr_addr] on wr_en when cnt < 2 and wr_addr < X_SIZE; otherwise it SHALL drop the write and set err.
REQ-022 SHALL, on wr_line_done when cnt < 2, increment cnt and toggle wbank; on wr_line_done when cnt == 2 it SHALL ignore the pulse and set err.
REQ-023 SHALL, on rd_line_release when cnt > 0, decrement cnt and toggle rbank; on release when cnt == 0 it SHALL ignore the pulse and set err.
REQ-024 SHALL, on a simultaneous accepted done and release, toggle both pointers and leave cnt unchanged; it SHALL evaluate done acceptance against the pre-edge cnt.
REQ-025 SHALL, on rd_en with rd_line_valid high, register bank[rbank][rd_addr] into rd_data and assert rd_data_valid on the next cycle, for 1-cycle latency.
REQ-026 SHALL, on rd_en with rd_line_valid low or rd_addr >= X_SIZE, drive rd_data_valid low next cycle and hold rd_data; an invalid address SHALL also set err.
REQ-027 SHALL deassert rd_data_valid on every cycle without an accepted read.
REQ-028 SHALL use the pre-edge rbank for a read issued in the same cycle as rd_line_release.
REQ-029 SHALL make a line visible to the consumer on the cycle after its accepted wr_line_done: rd_line_valid rises and reads return that line's data.
REQ-030 SHALL make the same-cycle read of a location being written in the read bank impossible: the write bank never equals the read bank while cnt == 1.
REQ-031 SHALL register start_req and pulse it for exactly one cycle after each of: the first cycle with reset low; an accepted wr_line_done leaving cnt < 2; an accepted rd_line_release from cnt == 2 with no accepted done in the same cycle.
REQ-032 SHALL keep err set until reset.

Reset
REQ-033 SHALL, while reset is high, force cnt=0, wbank=0, rbank=0, rd_data=0, rd_data_valid=0, start_req=0 and err=0, with wr_ready=1 and rd_line_valid=0.
REQ-034 SHALL NOT reset bank contents; data after reset is undefined until written.
REQ-035 SHALL, on reset asserted mid-line, discard all buffered lines and partial writes, then pulse start_req once after release.

Verification
REQ-036 Reset release -> start_req high for exactly one cycle, wr_ready=1, rd_line_valid=0, err=0.
REQ-037 Write addr 0..639 with data=addr, then pulse done -> next cycle rd_line_valid=1, cnt=1, start_req pulses; rd_en at addr 5 -> rd_data=5 with rd_data_valid=1 one cycle later.
REQ-038 Fill two lines (data 0x001, 0x002) without release -> wr_ready=0 and no start_req; a third write and done -> ignored, err=1; read -> 0x001; release -> start_req pulses, read returns 0x002.
REQ-039 cnt=1, simultaneous done and release -> cnt stays 1, both pointers toggle, start_req pulses, reads return the newly completed line.
REQ-040 Release with cnt=0, or rd_en with rd_addr=640 -> err=1, rd_data_valid=0, rd_data unchanged.
REQ-041 Reset asserted mid-line after 300 writes -> cnt=0, rd_line_valid=0, err=0; one start_req pulse after release.
